// File: rtl/tx_word_scheduler.sv
`default_nettype none
// ============================================================================
// tx_word_scheduler : queues 16-bit words, sends each high byte then low byte
// over a tx_start/tx_done byte UART; TX_CHECKSUM_EN adds an XOR checksum byte.
// Revision : 1.0
// ============================================================================
module tx_word_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             tx_done,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             overflow,
  output logic [PTR_W:0]   fifo_count
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_START_HI = 3'd2,
    S_WAIT_HI  = 3'd3,
    S_START_LO = 3'd4,
    S_WAIT_LO  = 3'd5
`ifdef TX_CHECKSUM_EN
    ,
    S_START_CK = 3'd6,
    S_WAIT_CK  = 3'd7
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [15:0]        word_q, word_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               overflow_q, overflow_d;
  logic               w_push, w_pop, w_full, w_nonempty;

  assign w_full     = (count_q == DEPTH_C);
  assign w_nonempty = (count_q != '0);
  assign w_push     = word_valid && !w_full;
  assign w_pop      = (state_q == S_LOAD) && w_nonempty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (word_valid && w_full);
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (!w_push && w_pop) count_d = count_q - 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: if (w_nonempty) state_d = S_LOAD;
      S_LOAD: begin
        word_d    = mem[rd_ptr_q];
        tx_data_d = mem[rd_ptr_q][15:8];
        state_d   = S_START_HI;
      end
      // Leave START only once our own request has been taken by the TX.
      S_START_HI: if (tx_start_q && !tx_done) state_d = S_WAIT_HI;
      S_WAIT_HI: if (tx_done) begin
        tx_data_d = word_q[7:0];
        state_d   = S_START_LO;
      end
      S_START_LO: if (tx_start_q && !tx_done) state_d = S_WAIT_LO;
      S_WAIT_LO: if (tx_done) begin
`ifdef TX_CHECKSUM_EN
        tx_data_d = word_q[15:8] ^ word_q[7:0];
        state_d   = S_START_CK;
`else
        state_d   = w_nonempty ? S_LOAD : S_IDLE;
`endif
      end
`ifdef TX_CHECKSUM_EN
      S_START_CK: if (tx_start_q && !tx_done) state_d = S_WAIT_CK;
      S_WAIT_CK: if (tx_done) state_d = w_nonempty ? S_LOAD : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Request a byte only while the TX reports idle, so a frame already in
  // flight (e.g. after a reset) is never interrupted.
  always_comb begin
    tx_start_d = 1'b0;
    if (tx_done) begin
      if (state_d == S_START_HI || state_d == S_START_LO) tx_start_d = 1'b1;
`ifdef TX_CHECKSUM_EN
      if (state_d == S_START_CK) tx_start_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem[wr_ptr_q] <= word_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end

  assign word_ready = !w_full;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = (state_q != S_IDLE) || w_nonempty;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_word_scheduler.sv
`default_nettype none
// Bench for tx_word_scheduler: byte-level TX model with a scoreboard of
// expected bytes, plus directed checks of latency, flow control and reset.
module tb_tx_word_scheduler;
  localparam int PW = 2;
`ifdef TX_CHECKSUM_EN
  localparam int BPW = 3;
`else
  localparam int BPW = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   word_in = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          tx_done = 1'b1;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          busy;
  logic          overflow;
  logic [PW:0]   fifo_count;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [7:0]    exp_q[$];
  logic [7:0]    exp_b;
  int            acc_cyc[$];
  int            n_acc = 0;
  int            cyc = 0;
  int            cnt = 0;
  int            frame_len = 3;
  bit            tx_stall = 1'b0;
  int            base;
  int            gap1, gap2;
  logic [15:0]   w5 [5] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005};

  always #5 clk = ~clk;

  tx_word_scheduler #(.FIFO_DEPTH(4), .PTR_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .tx_done    (tx_done),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(w[15:8] ^ w[7:0]);
`endif
  endtask

  task automatic push_word(input logic [15:0] w);
    @(negedge clk);
    word_in    = w;
    word_valid = 1'b1;
    push_exp(w);
    @(posedge clk);
    #1 word_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (i < 3000 && !(exp_q.size() == 0 && !busy && tx_done)) begin
      @(negedge clk); #2;
      i++;
    end
    check({name, "_drain_in_time"}, 32'(i < 3000), 32'd1);
    check({name, "_bytes_left"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_acc(input int target, input string name);
    int i = 0;
    while (i < 500 && n_acc < target) begin
      @(negedge clk); #2;
      i++;
    end
    check({name, "_accept_in_time"}, 32'(i < 500), 32'd1);
  endtask

  initial begin
    fork
      // TX byte model and scoreboard monitor
      forever begin
        @(negedge clk);
        cyc++;
        if (tx_stall) begin
          tx_done = 1'b0;
        end else if (tx_done && tx_start) begin
          n_acc++;
          acc_cyc.push_back(cyc);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL tx_byte: got 0x%02h, expected no byte", tx_data);
          end else begin
            exp_b = exp_q.pop_front();
            if (tx_data !== exp_b) begin
              n_err++;
              $display("FAIL tx_byte #%0d: got 0x%02h, expected 0x%02h", n_acc, tx_data, exp_b);
            end
          end
          tx_done = 1'b0;
          cnt     = frame_len;
        end else if (!tx_done) begin
          if (cnt == 0) tx_done = 1'b1;
          else cnt--;
        end
      end

      begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(word_ready), 32'd1);
        @(negedge clk); rst = 1'b0;

        // Single word latency: tx_start high after edge E+2
        @(negedge clk);
        word_in = 16'hA55A; word_valid = 1'b1; push_exp(16'hA55A);
        @(posedge clk); #1 word_valid = 1'b0;
        check("t1_count_E", 32'(fifo_count), 32'd1);
        check("t1_start_E", 32'(tx_start), 32'd0);
        @(posedge clk); #1;
        check("t1_start_E1", 32'(tx_start), 32'd0);
        @(posedge clk); #1;
        check("t1_start_E2", 32'(tx_start), 32'd1);
        check("t1_data_E2", 32'(tx_data), 32'hA5);
        check("t1_count_E2", 32'(fifo_count), 32'd0);
        wait_drain("t1");

        // Back-to-back words, no IDLE gap between them
        base = acc_cyc.size();
        push_word(16'h1234);
        push_word(16'hBEEF);
        wait_drain("t2");
        if (acc_cyc.size() >= base + 2 * BPW) begin
          gap1 = acc_cyc[base + 1] - acc_cyc[base];
          gap2 = acc_cyc[base + BPW] - acc_cyc[base + BPW - 1];
        end else begin
          gap1 = -1;
          gap2 = -1;
        end
        check("t2_hi_lo_gap", 32'(gap1), 32'd5);
        check("t2_word_gap", 32'(gap2), 32'd6);

        // TX stalled: fill FIFO behind a held word, overflow on the 5th push
        @(negedge clk); tx_stall = 1'b1;
        push_word(16'hC0DE);
        repeat (4) @(posedge clk);
        #1;
        check("t3_hold_start", 32'(tx_start), 32'd0);
        check("t3_hold_count", 32'(fifo_count), 32'd0);
        check("t3_hold_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          word_in = w5[i]; word_valid = 1'b1;
          if (i < 4) push_exp(w5[i]);
          else begin
            check("t3_ready_full", 32'(word_ready), 32'd0);
            check("t3_ovf_before", 32'(overflow), 32'd0);
          end
        end
        @(posedge clk); #1 word_valid = 1'b0;
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_count_full", 32'(fifo_count), 32'd4);
        check("t3_ready_after", 32'(word_ready), 32'd0);
        @(negedge clk); tx_stall = 1'b0;
        wait_drain("t3");
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Reset during WAIT_LO with the TX still mid-frame
        frame_len = 12;
        base = n_acc;
        push_word(16'h00FF);
        wait_acc(base + 2, "t4");
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("t4_rst_start", 32'(tx_start), 32'd0);
        check("t4_rst_count", 32'(fifo_count), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_ovf", 32'(overflow), 32'd0);
        check("t4_rst_data", 32'(tx_data), 32'd0);
        check("t4_pending", exp_q.size(), 32'(BPW - 2));
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        push_word(16'h0102);
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          check("t4_wait_tx_idle", 32'(tx_start), 32'd0);
        end
        frame_len = 3;
        wait_drain("t4");

        // Push and pop in the same cycle at count=1, then wrap the pointers
        base = n_acc;
        push_word(16'h1111);
        push_word(16'h2222);
        wait_acc(base + BPW, "t5");
        repeat (5) @(negedge clk);
        word_in = 16'h3333; word_valid = 1'b1; push_exp(16'h3333);
        @(posedge clk); #1 word_valid = 1'b0;
        check("t5_pushpop_count", 32'(fifo_count), 32'd1);
        push_word(16'hF00F);
        push_word(16'h4444);
        push_word(16'h5555);
        wait_drain("t5");

        check("end_bytes_left", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    join_any
  end

endmodule
`default_nettype wire
